alu_bcd_sequencer: RTL and testbench
====================================

// Module: alu_bcd_sequencer
// PURPOSE
//  Multi-cycle controller that owns the shared 8-bit ALU while servicing one add/sub request.
//  Binary ops take one ALU pass. Decimal (BCD) ops take up to three passes: binary,
//  low-nibble adjust, high-nibble adjust.
//  Sits between the instruction decoder and the ALU input muxes. alu_sel hands the ALU back to
//  the main datapath when idle.
// PARAMETERS
//  FIXED_LAT  1     1: decimal ops always run 3 ALU passes; 0: skip adjust passes that add 0
//  ADD_OP     4'h2  ALU op code for add (y = a + b + c_in)
//  SUB_OP     4'h3  ALU op code for sub (y = b + ~a + c_in, i.e. b - a - !c_in)
// PORTS
//  clk         in   1  clock, all state on rising edge
//  reset       in   1  synchronous, active-high
//  req_valid   in   1  request present
//  req_ready   out  1  high only in IDLE; request accepted on req_valid & req_ready
//  req_sub     in   1  0 add, 1 subtract (req_b - req_a - !req_c)
//  req_bcd     in   1  decimal mode
//  req_a       in   8  ALU a operand (subtrahend for sub)
//  req_b       in   8  ALU b operand (minuend for sub)
//  req_c       in   1  carry in (inverted borrow for sub)
//  alu_sel     out  1  1 = sequencer drives ALU inputs
//  alu_a       out  8  ALU a
//  alu_b       out  8  ALU b
//  alu_op      out  4  ALU op
//  alu_c_in    out  1  ALU carry in
//  alu_y       in   8  ALU result
//  alu_c_out   in   1  ALU carry out
//  alu_zero, alu_negative, alu_overflow  in  1 each  ALU flags
//  done        out  1  one-cycle pulse: result/flags valid
//  result      out  8  final result, held until next done
//  c_out, zero, negative, overflow  out  1 each  final flags, held with result
// BEHAVIOUR
//  Reset: state=IDLE. req_ready=1, alu_sel=0, done=0, result=0, all flags 0. Clears any op in flight.
//  States: IDLE -> BIN -> [ADJ_LO -> ADJ_HI] -> DONE -> IDLE.
//  - IDLE: on accept, register operands, sub, bcd and carry. Go to BIN. req_valid is ignored in
//    any other state.
//  - BIN: alu_sel=1. Drive req_a, req_b and req_c with ADD_OP/SUB_OP. Capture alu_y into r,
//    alu_c_out into c1, and the binary Z/N/V flags.
//    Also compute the low nibble locally, lo = a[3:0] +/- b[3:0] +/- carry.
//      Add: lo_adj = (lo > 9).
//      Sub: lo_adj = low-nibble borrow.
//    Next state: DONE if !bcd; otherwise ADJ_LO.
//  - ADJ_LO: if lo_adj, apply the nibble fix; otherwise pass 0.
//      Add: alu_a = r, alu_b = 0x06, op = ADD, c_in = 0.
//      Sub: alu_a = 0x06, alu_b = r, op = SUB, c_in = 1.
//    Add only: OR alu_c_out into c1.
//  - ADJ_HI: hi_adj is decided as follows.
//      Add: hi_adj = c1 | (r[7:4] > 9).
//      Sub: hi_adj = !c1.
//    Same form with 0x60. Add: hi_adj forces c1 = 1.
//  - FIXED_LAT=0: an adjust state whose adj bit is 0 is skipped. alu_sel stays 0 in that cycle.
//  - DONE: done=1. result = r, c_out = c1. zero/negative/overflow come from the BIN pass.
//    Always return to IDLE next cycle.
//  - Latency, counted from the accept edge to the done-high cycle:
//      binary: 2 cycles
//      decimal, FIXED_LAT=1: 4 cycles
//      decimal, FIXED_LAT=0: 2 to 4 cycles
//  - Back-to-back throughput: one accept every (latency + 1) cycles.
//  - When alu_sel=0, alu_a/alu_b/alu_c_in are 0 and alu_op is 4'hf (don't care).
//  - Non-BCD operands in decimal mode: the same nibble rules apply; the result is unspecified but
//    deterministic.
//  - Arithmetic is 8-bit; nibble adds wrap mod 16, byte adds wrap mod 256.
// CONFIGURATION
//  ALU_SEQ_CMOS_FLAGS_EN defined: in decimal mode, zero and negative come from the final result
//  r (65C02 style). Latency is unchanged.
//  Not defined: zero/negative/overflow are always the BIN-pass values (NMOS style).
//  Binary mode is identical either way.
// TESTING
//  1. Binary add 0x34+0x12, c=0 -> result 0x46, c_out=0, done 2 cycles after accept.
//  2. BCD add 0x15+0x27, c=0 -> 0x42, c_out=0. BCD add 0x99+0x01, c=0 -> 0x00, c_out=1.
//     That case gives zero=0, negative=1 without the macro; zero=1, negative=0 with it.
//  3. BCD sub, a=0x15, b=0x42, c=1 -> 0x27, c_out=1. BCD sub, a=0x01, b=0x00, c=1 -> 0x99, c_out=0.
//  4. FIXED_LAT=0: BCD add 0x11+0x22 -> 0x33, done 2 cycles after accept.
//     FIXED_LAT=1: same request, done 4 cycles after accept.
//  5. req_valid held high during a busy op -> no second accept until IDLE. alu_sel=0 in IDLE.
//  6. Reset asserted in ADJ_LO -> next cycle IDLE, done=0, result=0, req_ready=1. No done pulse follows.

Source files
------------

// File: rtl/alu_bcd_sequencer.sv
// Sequences one binary or BCD add/sub through a shared 8-bit ALU (bin pass plus nibble adjusts).
// Define ALU_SEQ_CMOS_FLAGS_EN to take decimal-mode zero/negative from the adjusted result.
module alu_bcd_sequencer #(
  parameter bit         FIXED_LAT = 1'b1,
  parameter logic [3:0] ADD_OP    = 4'h2,
  parameter logic [3:0] SUB_OP    = 4'h3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_sub,
  input  logic       req_bcd,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_c,
  output logic       alu_sel,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  output logic       alu_c_in,
  input  logic [7:0] alu_y,
  input  logic       alu_c_out,
  input  logic       alu_zero,
  input  logic       alu_negative,
  input  logic       alu_overflow,
  output logic       done,
  output logic [7:0] result,
  output logic       c_out,
  output logic       zero,
  output logic       negative,
  output logic       overflow
);

  typedef enum logic [2:0] {IDLE, BIN, ADJ_LO, ADJ_HI, DONE} state_t;

  state_t     state, state_n;
  logic [7:0] op_a, op_b, r, r_n;
  logic       op_sub, op_bcd, op_c, c1, c1_n;
  logic       bin_zero, bin_negative, bin_overflow;
  logic [4:0] lo_sum;
  logic       lo_adj, hi_adj, lo_go, hi_go;
  logic [7:0] fix, a_n, b_n;
  logic [3:0] op_n;
  logic       sel_n, c_in_n;

  function automatic logic hi_rule(input logic sub, input logic [7:0] val, input logic carry);
    return sub ? ~carry : (carry | (val[7:4] > 4'd9));
  endfunction

  // Low-nibble decision works on the captured operands, so it is stable from BIN onward.
  always_comb begin
    if (op_sub) lo_sum = {1'b0, op_b[3:0]} + {1'b0, ~op_a[3:0]} + {4'd0, op_c};
    else        lo_sum = {1'b0, op_a[3:0]} + {1'b0, op_b[3:0]} + {4'd0, op_c};
    lo_adj = op_sub ? ~lo_sum[4] : (lo_sum > 5'd9);
  end

  // Next state plus the ALU drive for the pass that state runs, so the ALU inputs are registered.
  always_comb begin
    state_n = state;
    r_n     = r;
    c1_n    = c1;
    lo_go   = 1'b0;
    hi_go   = 1'b0;
    hi_adj  = 1'b0;
    case (state)
      IDLE: if (req_valid) state_n = BIN;
      BIN: begin
        r_n    = alu_y;
        c1_n   = alu_c_out;
        hi_adj = hi_rule(op_sub, alu_y, alu_c_out);
        if (!op_bcd) state_n = DONE;
        else if (FIXED_LAT || lo_adj) begin
          state_n = ADJ_LO;
          lo_go   = 1'b1;
        end else if (hi_adj) begin
          state_n = ADJ_HI;
          hi_go   = 1'b1;
        end else state_n = DONE;
      end
      ADJ_LO: begin
        r_n    = alu_y;
        c1_n   = op_sub ? c1 : (c1 | alu_c_out);
        hi_adj = hi_rule(op_sub, r_n, c1_n);
        if (FIXED_LAT || hi_adj) begin
          state_n = ADJ_HI;
          hi_go   = 1'b1;
        end else state_n = DONE;
      end
      ADJ_HI: begin
        r_n     = alu_y;
        c1_n    = op_sub ? c1 : (c1 | hi_rule(1'b0, r, c1));
        state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    fix    = lo_go ? (lo_adj ? 8'h06 : 8'h00) : (hi_adj ? 8'h60 : 8'h00);
    sel_n  = 1'b0;
    a_n    = 8'h00;
    b_n    = 8'h00;
    op_n   = 4'hf;
    c_in_n = 1'b0;
    if (state == IDLE && req_valid) begin
      sel_n  = 1'b1;
      a_n    = req_a;
      b_n    = req_b;
      op_n   = req_sub ? SUB_OP : ADD_OP;
      c_in_n = req_c;
    end else if (lo_go || hi_go) begin
      sel_n = 1'b1;
      if (op_sub) begin
        a_n    = fix;
        b_n    = r_n;
        op_n   = SUB_OP;
        c_in_n = 1'b1;
      end else begin
        a_n    = r_n;
        b_n    = fix;
        op_n   = ADD_OP;
        c_in_n = 1'b0;
      end
    end
  end

  // Sequencer state, operand capture and the held result/flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      r            <= 8'h00;
      c1           <= 1'b0;
      op_a         <= 8'h00;
      op_b         <= 8'h00;
      op_sub       <= 1'b0;
      op_bcd       <= 1'b0;
      op_c         <= 1'b0;
      bin_zero     <= 1'b0;
      bin_negative <= 1'b0;
      bin_overflow <= 1'b0;
      req_ready    <= 1'b1;
      alu_sel      <= 1'b0;
      alu_a        <= 8'h00;
      alu_b        <= 8'h00;
      alu_op       <= 4'hf;
      alu_c_in     <= 1'b0;
      done         <= 1'b0;
      result       <= 8'h00;
      c_out        <= 1'b0;
      zero         <= 1'b0;
      negative     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state     <= state_n;
      r         <= r_n;
      c1        <= c1_n;
      alu_sel   <= sel_n;
      alu_a     <= a_n;
      alu_b     <= b_n;
      alu_op    <= op_n;
      alu_c_in  <= c_in_n;
      req_ready <= (state_n == IDLE);
      done      <= (state == DONE);
      if (state == IDLE && req_valid) begin
        op_a   <= req_a;
        op_b   <= req_b;
        op_sub <= req_sub;
        op_bcd <= req_bcd;
        op_c   <= req_c;
      end
      if (state == BIN) begin
        bin_zero     <= alu_zero;
        bin_negative <= alu_negative;
        bin_overflow <= alu_overflow;
      end
      if (state == DONE) begin
        result   <= r;
        c_out    <= c1;
        overflow <= bin_overflow;
`ifdef ALU_SEQ_CMOS_FLAGS_EN
        zero     <= op_bcd ? (r == 8'h00) : bin_zero;
        negative <= op_bcd ? r[7] : bin_negative;
`else
        zero     <= bin_zero;
        negative <= bin_negative;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_bcd_sequencer.sv
// Bench for alu_bcd_sequencer: instance 0 has FIXED_LAT=1, instance 1 FIXED_LAT=0, each with an ALU model.
// Honours ALU_SEQ_CMOS_FLAGS_EN in its reference model.
module tb_alu_bcd_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_sub, req_bcd, req_c;
  logic [7:0] req_a, req_b;

  logic [1:0]      req_ready, alu_sel, alu_c_in, alu_c_out, alu_zero, alu_negative, alu_overflow;
  logic [1:0]      done, c_out, zero, negative, overflow;
  logic [1:0][7:0] alu_a, alu_b, alu_y, result;
  logic [1:0][3:0] alu_op;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_res;
  logic       exp_co, exp_z, exp_n, exp_v;
  int         exp_lat [2];
  logic [7:0] obs_res [2];
  logic       obs_co [2], obs_z [2], obs_n [2], obs_v [2];
  int         obs_lat [2], obs_pulses [2];

  always #5 clk = ~clk;

  // Shared ALU stand-in: op 4'h3 subtracts, anything else adds.
  function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op, input logic cin);
    logic [8:0] s;
    logic       v;
    if (op == 4'h3) begin
      s = {1'b0, b} + {1'b0, ~a} + {8'd0, cin};
      v = (a[7] != b[7]) && (s[7] != b[7]);
    end else begin
      s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      v = (a[7] == b[7]) && (s[7] != a[7]);
    end
    return {v, s[7], (s[7:0] == 8'h00), s[8], s[7:0]};
  endfunction

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      alu_bcd_sequencer #(.FIXED_LAT(g == 0)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[g]),
        .req_sub(req_sub), .req_bcd(req_bcd), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .alu_sel(alu_sel[g]), .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_op(alu_op[g]),
        .alu_c_in(alu_c_in[g]), .alu_y(alu_y[g]), .alu_c_out(alu_c_out[g]),
        .alu_zero(alu_zero[g]), .alu_negative(alu_negative[g]), .alu_overflow(alu_overflow[g]),
        .done(done[g]), .result(result[g]), .c_out(c_out[g]), .zero(zero[g]),
        .negative(negative[g]), .overflow(overflow[g]));
      assign {alu_overflow[g], alu_negative[g], alu_zero[g], alu_c_out[g], alu_y[g]} =
        alu_model(alu_a[g], alu_b[g], alu_op[g], alu_c_in[g]);
    end
  endgenerate

  // Decimal-arithmetic reference using plain integers.
  task automatic ref_op(input logic sub, input logic bcd, input logic [7:0] a,
                        input logic [7:0] b, input logic c);
    int ai, bi, ci, sa, sb, bin, r, sv, lo, hi;
    bit carry;
    ai = a; bi = b; ci = c;
    sa = (ai > 127) ? ai - 256 : ai;
    sb = (bi > 127) ? bi - 256 : bi;
    lo = 0; hi = 0;
    if (!sub) begin
      bin = ai + bi + ci;
      carry = (bin > 255);
      bin = bin % 256;
      sv = sa + sb + ci;
      r = bin;
      if (bcd) begin
        lo = ((ai % 16) + (bi % 16) + ci > 9) ? 1 : 0;
        r = bin + 6 * lo;
        if (r > 255) carry = 1;
        r = r % 256;
        hi = (carry || (r / 16 > 9)) ? 1 : 0;
        r = (r + 96 * hi) % 256;
        if (hi != 0) carry = 1;
      end
    end else begin
      bin = bi - ai - (1 - ci);
      carry = (bin >= 0);
      bin = (bin + 256) % 256;
      sv = sb - sa - (1 - ci);
      r = bin;
      if (bcd) begin
        lo = ((bi % 16) - (ai % 16) - (1 - ci) < 0) ? 1 : 0;
        r = (bin - 6 * lo + 256) % 256;
        hi = carry ? 0 : 1;
        r = (r - 96 * hi + 256) % 256;
      end
    end
    exp_res = r[7:0];
    exp_co  = carry;
    exp_v   = (sv > 127) || (sv < -128);
    exp_z   = (bin == 0);
    exp_n   = (bin > 127);
`ifdef ALU_SEQ_CMOS_FLAGS_EN
    if (bcd) begin
      exp_z = (r == 0);
      exp_n = (r > 127);
    end
`endif
    exp_lat[0] = bcd ? 4 : 2;
    exp_lat[1] = bcd ? 2 + lo + hi : 2;
  endtask

  // Issues one request and records each instance's first done (bounded to 8 cycles).
  task automatic exec_op(input logic sub, input logic bcd, input logic [7:0] a,
                         input logic [7:0] b, input logic c);
    @(negedge clk);
    req_sub = sub; req_bcd = bcd; req_a = a; req_b = b; req_c = c; req_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      obs_lat[k] = -1;
      obs_pulses[k] = 0;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (done[k]) begin
          obs_pulses[k]++;
          if (obs_lat[k] < 0) begin
            obs_lat[k] = t;
            obs_res[k] = result[k];
            obs_co[k] = c_out[k];
            obs_z[k] = zero[k];
            obs_n[k] = negative[k];
            obs_v[k] = overflow[k];
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_sub = 1'b0; req_bcd = 1'b0;
    req_a = 8'h00; req_b = 8'h00; req_c = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({req_ready[k], alu_sel[k], done[k], result[k], c_out[k], zero[k], negative[k], overflow[k]} !== 15'h4000) begin
        miscompares++;
        $display("[TB] FAIL reset_outputs[%0d]: got ready=%b sel=%b done=%b res=%h c=%b z=%b n=%b v=%b, expected ready=1 and all else 0",
                 k, req_ready[k], alu_sel[k], done[k], result[k], c_out[k], zero[k], negative[k], overflow[k]);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({alu_sel[k], alu_a[k], alu_b[k], alu_c_in[k], alu_op[k]} !== 22'h00000f) begin
        miscompares++;
        $display("[TB] FAIL idle_alu_drive[%0d]: got sel=%b a=%h b=%h cin=%b op=%h, expected 0/00/00/0/f",
                 k, alu_sel[k], alu_a[k], alu_b[k], alu_c_in[k], alu_op[k]);
      end
    end
  endtask

  task automatic test_arith();
    logic       s, bd, c;
    logic [7:0] a, b;
    for (int i = 0; i < 46; i++) begin
      case (i)
        0: {s, bd, a, b, c} = {1'b0, 1'b0, 8'h34, 8'h12, 1'b0};
        1: {s, bd, a, b, c} = {1'b0, 1'b1, 8'h15, 8'h27, 1'b0};
        2: {s, bd, a, b, c} = {1'b0, 1'b1, 8'h99, 8'h01, 1'b0};
        3: {s, bd, a, b, c} = {1'b1, 1'b1, 8'h15, 8'h42, 1'b1};
        4: {s, bd, a, b, c} = {1'b1, 1'b1, 8'h01, 8'h00, 1'b1};
        5: {s, bd, a, b, c} = {1'b0, 1'b1, 8'h11, 8'h22, 1'b0};
        default: begin
          s = 1'($urandom); bd = 1'($urandom); c = 1'($urandom);
          a = 8'($urandom); b = 8'($urandom);
        end
      endcase
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (req_ready[k] !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL ready_before_op[%0d]: got %b, expected 1", k, req_ready[k]);
        end
      end
      exec_op(s, bd, a, b, c);
      ref_op(s, bd, a, b, c);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_lat[k] !== exp_lat[k]) begin
          miscompares++;
          $display("[TB] FAIL latency[%0d] sub=%b bcd=%b a=%h b=%h c=%b: got %0d, expected %0d", k, s, bd, a, b, c, obs_lat[k], exp_lat[k]);
        end
        vectors++;
        if (obs_pulses[k] !== 1) begin
          miscompares++;
          $display("[TB] FAIL done_pulses[%0d]: got %0d, expected 1", k, obs_pulses[k]);
        end
        vectors++;
        if (obs_res[k] !== exp_res || obs_co[k] !== exp_co) begin
          miscompares++;
          $display("[TB] FAIL result[%0d] sub=%b bcd=%b a=%h b=%h c=%b: got %h c_out=%b, expected %h c_out=%b",
                   k, s, bd, a, b, c, obs_res[k], obs_co[k], exp_res, exp_co);
        end
        vectors++;
        if ({obs_z[k], obs_n[k], obs_v[k]} !== {exp_z, exp_n, exp_v}) begin
          miscompares++;
          $display("[TB] FAIL flags_znv[%0d] sub=%b bcd=%b a=%h b=%h c=%b: got %b%b%b, expected %b%b%b",
                   k, s, bd, a, b, c, obs_z[k], obs_n[k], obs_v[k], exp_z, exp_n, exp_v);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_done [2], n_ready [2], n_sel [2];
    for (int k = 0; k < 2; k++) begin
      n_done[k] = 0; n_ready[k] = 0; n_sel[k] = 0;
    end
    @(negedge clk);
    req_sub = 1'b0; req_bcd = 1'b0; req_a = 8'h34; req_b = 8'h12; req_c = 1'b0; req_valid = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (done[k]) n_done[k]++;
        if (req_ready[k]) n_ready[k]++;
        if (alu_sel[k]) n_sel[k]++;
      end
    end
    req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (n_done[k] !== 4 || n_ready[k] !== 4 || n_sel[k] !== 4) begin
        miscompares++;
        $display("[TB] FAIL back_to_back[%0d]: got done=%0d ready=%0d sel=%0d cycles, expected 4/4/4", k, n_done[k], n_ready[k], n_sel[k]);
      end
      vectors++;
      if (result[k] !== 8'h46) begin
        miscompares++;
        $display("[TB] FAIL back_to_back_result[%0d]: got %h, expected 46", k, result[k]);
      end
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_mid_op();
    int n_done [2];
    @(negedge clk);
    req_sub = 1'b0; req_bcd = 1'b1; req_a = 8'h15; req_b = 8'h27; req_c = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (alu_sel[k] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL adj_lo_sel[%0d]: got %b, expected 1", k, alu_sel[k]);
      end
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_done[k] = 0;
      vectors++;
      if ({done[k], result[k], req_ready[k], alu_sel[k]} !== 11'b0_00000000_1_0) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_op[%0d]: got done=%b res=%h ready=%b sel=%b, expected 0/00/1/0",
                 k, done[k], result[k], req_ready[k], alu_sel[k]);
      end
    end
    for (int t = 0; t < 6; t++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) if (done[k]) n_done[k]++;
    end
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (n_done[k] !== 0) begin
        miscompares++;
        $display("[TB] FAIL no_done_after_reset[%0d]: got %0d pulses, expected 0", k, n_done[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
